// File: rtl/axil_mem_arbiter.sv
// -----------------------------------------------------------------------------
// axil_mem_arbiter
//
// Shares one memory port between the AXI4-Lite slave read path (AR/R) and
// write path (AW/W/B). One request from each path may be pending; the port is
// granted to one path at a time, the access is run on the MVALID/MREADY
// handshake, and the result is handed back to the owning path as a one-cycle
// done pulse. An access that sees no MREADY within TIMEOUT cycles is aborted
// and completed with SLVERR.
//
// Ports:
//   clk, resetn                  clock (rising edge), async active-low reset
//   rd_req, rd_addr              read path request and address
//   rd_done, rd_data, rd_resp    read completion pulse, data and response
//   wr_req, wr_addr, wr_data,    write path request, address, data and
//   wr_strb                        byte strobes
//   wr_done, wr_resp             write completion pulse and response
//   MVALID, MWE, MADDR,          memory request, direction, address,
//   MWDATA, MSTRB                  write data and byte strobes
//   MREADY, MDATA, MRESP         memory completion, read data and response
// -----------------------------------------------------------------------------
module axil_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      rd_req,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic                      rd_done,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [1:0]                rd_resp,
  input  logic                      wr_req,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_strb,
  output logic                      wr_done,
  output logic [1:0]                wr_resp,
  output logic                      MVALID,
  output logic                      MWE,
  output logic [ADDR_WIDTH-1:0]     MADDR,
  output logic [DATA_WIDTH-1:0]     MWDATA,
  output logic [DATA_WIDTH/8-1:0]   MSTRB,
  input  logic                      MREADY,
  input  logic [DATA_WIDTH-1:0]     MDATA,
  input  logic [1:0]                MRESP
);

  localparam logic [1:0] RESP_SLVERR = 2'b10;
  // TIMEOUT is at most 255, so an 8-bit counter always reaches the last value.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       last_wr;
  logic       grant_wr;

  // Under contention the path that did not get the previous grant wins, which
  // gives strict alternation; otherwise whichever path is requesting wins.
  always_comb begin
    grant_wr = 1'b0;
    if (rd_req && wr_req) begin
      grant_wr = !last_wr;
    end else begin
      grant_wr = wr_req;
    end
  end

  // Arbitration and access sequencing. The done pulses default low every
  // cycle so they are high only in the RESP cycle that follows completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      last_wr <= 1'b1;
      MVALID  <= 1'b0;
      MWE     <= 1'b0;
      MADDR   <= '0;
      MWDATA  <= '0;
      MSTRB   <= '0;
      rd_done <= 1'b0;
      rd_data <= '0;
      rd_resp <= '0;
      wr_done <= 1'b0;
      wr_resp <= '0;
    end else begin
      rd_done <= 1'b0;
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req || wr_req) begin
            MVALID <= 1'b1;
            MWE    <= grant_wr;
            cnt    <= '0;
            state  <= ACCESS;
            if (grant_wr) begin
              MADDR  <= wr_addr;
              MWDATA <= wr_data;
              MSTRB  <= wr_strb;
            end else begin
              MADDR  <= rd_addr;
              MWDATA <= '0;
              MSTRB  <= '0;
            end
          end
        end
        ACCESS: begin
          // MREADY is checked first so it wins over a coincident timeout.
          if (MREADY || (cnt == CNT_LAST)) begin
            MVALID <= 1'b0;
            state  <= RESP;
            if (MWE) begin
              wr_done <= 1'b1;
              wr_resp <= MREADY ? MRESP : RESP_SLVERR;
            end else begin
              rd_done <= 1'b1;
              rd_resp <= MREADY ? MRESP : RESP_SLVERR;
              rd_data <= MREADY ? MDATA : '0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          // MWE still identifies the path that owned the access just finished.
          last_wr <= MWE;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axil_mem_arbiter.md
Name: axil_mem_arbiter

Overview:
- Shares the single memory port between the AXI4-Lite slave read path (AR/R) and write path (AW/W/B).
- Accepts one request from each path, grants the memory port to one at a time, and sequences the memory access.
- Returns the memory data and response to the owning path, and enforces a response timeout.
- Sits between the channel blocks and the memory-side MVALID/MREADY/MDATA/MRESP interface.

Parameters:
ADDR_WIDTH, 32, byte address width of the memory port
DATA_WIDTH, 32, data width (multiple of 8)
TIMEOUT, 16, cycles to wait for MREADY before aborting with SLVERR (legal range 2..255)

Ports:
clk  input  1  clock, all logic on rising edge
resetn  input  1  reset, asynchronous assert, active low
rd_req  input  1  read path requests memory access
rd_addr  input  ADDR_WIDTH  read address, valid while rd_req=1
rd_done  output  1  one-cycle pulse: read access complete
rd_data  output  DATA_WIDTH  read data, valid with rd_done
rd_resp  output  2  read response (00 OKAY, 10 SLVERR), valid with rd_done
wr_req  input  1  write path requests memory access
wr_addr  input  ADDR_WIDTH  write address, valid while wr_req=1
wr_data  input  DATA_WIDTH  write data
wr_strb  input  DATA_WIDTH/8  byte strobes
wr_done  output  1  one-cycle pulse: write access complete
wr_resp  output  2  write response, valid with wr_done
MVALID  output  1  memory access request
MWE  output  1  1=write, 0=read, valid with MVALID
MADDR  output  ADDR_WIDTH  memory address
MWDATA  output  DATA_WIDTH  memory write data
MSTRB  output  DATA_WIDTH/8  memory byte strobes (all zero on reads)
MREADY  input  1  memory completes the access this cycle
MDATA  input  DATA_WIDTH  memory read data, valid with MREADY
MRESP  input  2  memory response, valid with MREADY

Behaviour:
- Reset (resetn=0, async): state=IDLE, all outputs 0, counter 0, lastGrant=WRITE (so read wins the first tie).
- States: IDLE -> ACCESS -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - If rd_req and wr_req are both 1: grant the path opposite to lastGrant.
  - Else grant whichever request is 1.
  - On grant: latch address/data/strobes into MADDR/MWDATA/MSTRB, set MWE, set MVALID=1, clear counter, go to ACCESS.
  - First MVALID is seen one cycle after the request is sampled.
- ACCESS:
  - MVALID and all M* outputs are held stable; counter increments every cycle.
  - MREADY=1: capture MDATA (reads only) and MRESP, drop MVALID, go to RESP.
  - Counter reaches TIMEOUT-1 with MREADY=0: drop MVALID, response=2'b10, data=0, go to RESP.
  - MREADY in the same cycle as the timeout: MREADY wins.
- RESP:
  - Pulse rd_done or wr_done for exactly one cycle with the response/data.
  - Update lastGrant; go to IDLE.
  - rd_data/rd_resp/wr_resp hold their values until the next completion.
- Requester contract: the requester deasserts req in the cycle after its done pulse. A req still high in IDLE is treated as a new request.
- Minimum round trip with MREADY returned in the first ACCESS cycle is 3 cycles, req sample to IDLE.
- No back-to-back grant to the same path while the other path is pending; strict alternation under contention.
- MREADY/MDATA/MRESP are ignored outside ACCESS.
- MSTRB=0 and MWDATA=0 on reads; rd_data is not updated on writes.
- A request arriving during ACCESS/RESP waits; its inputs are not sampled until IDLE.
- Reset mid-access: immediate return to IDLE, MVALID=0 asynchronously, no done pulse; any in-flight access is discarded.

Test Plan:
- Single read: rd_addr=0x10, MREADY on 2nd ACCESS cycle with MDATA=0xDEADBEEF, MRESP=00 -> MVALID=1/MWE=0/MADDR=0x10 for 2 cycles, then rd_done=1 for one cycle with rd_data=0xDEADBEEF, rd_resp=00; wr_done stays 0.
- Single write: wr_addr=0x20, wr_data=0x12345678, wr_strb=4'b0011, MRESP=00 -> MWE=1, MSTRB=0011, MWDATA=0x12345678, then wr_done pulse with wr_resp=00; rd_data unchanged.
- Contention after reset: rd_req and wr_req both held high -> grant order read, write, read, write; each done pulse appears exactly once per grant.
- Timeout: read with MREADY tied 0, TIMEOUT=16 -> MVALID high for exactly 16 cycles, then rd_done with rd_resp=10, rd_data=0.
- MREADY coincides with the last timeout cycle, MRESP=00 -> rd_resp=00 and MDATA captured.
- Reset mid-access: assert resetn=0 in the 2nd ACCESS cycle -> MVALID=0 immediately, no done pulse; after release a new read completes normally.
